// File: rtl/ram_handshake_responder.sv
// ram_handshake_responder
//   Memory-side responder for the control unit's MOV/RAMEnable/RW request
//   handshake. A request is latched in IDLE, WAIT_CYCLES wait states are
//   inserted, then one access is made to a 2**ADDR_W x 32-bit word array and
//   MOC is raised. MOC stays high until the control unit drops MOV.
//
//   Handshake (four-phase): the requester raises ram_enable & mov with rw,
//   addr and wdata stable; the responder samples them on one edge in IDLE and
//   ignores the inputs from then on. moc=1 (with err and rdata valid) is the
//   completion. The requester holds mov high until it sees moc, then drops
//   mov; moc and err fall on the next edge that sees mov=0. Dropping mov while
//   wait states are still counting cancels the request with no access.
//
// Parameters
//   ADDR_W       word-address width; addr[ADDR_W+1:2] selects the word
//   WAIT_CYCLES  wait states between acceptance and access (0..15)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; aborts any operation, storage kept
//   ram_enable  request qualifier
//   mov         memory operation valid, held until moc is seen
//   rw          1 = read, 0 = write
//   addr        byte address
//   wdata       store data
//   rdata       registered load data, holds the last read value
//   moc         memory operation complete (registered)
//   err         misaligned or out-of-range request, valid while moc=1
//   dbgState    current FSM state: 0 idle, 1 wait, 2 access, 3 done
module ram_handshake_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ram_enable,
   input  logic        mov,
   input  logic        rw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        moc,
   output logic        err,
   output logic [1:0]  dbgState
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

   state_t            state;
   logic [3:0]        waitCnt;
   logic              latRw;
   logic [31:0]       latAddr;
   logic [31:0]       latWdata;
   logic [ADDR_W-1:0] latIdx;
   logic              latLegal;
   logic              memWe;

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   // Only the latched request drives the access; live inputs are ignored
   // once the request has been accepted.
   assign latIdx   = latAddr[ADDR_W+1:2];
   assign latLegal = (latAddr[1:0] == 2'b00) && (latAddr[31:ADDR_W+2] == '0);

   assign dbgState = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         moc     <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         waitCnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ram_enable && mov) begin
                  latRw    <= rw;
                  latAddr  <= addr;
                  latWdata <= wdata;
                  waitCnt  <= WaitLoad;
                  state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Cancellation wins over completing the count.
               if (!mov) begin
                  state <= ST_IDLE;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
                  if (waitCnt == 4'd1) state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               moc <= 1'b1;
               if (!latLegal) err <= 1'b1;
               else if (latRw) rdata <= mem[latIdx];
               state <= ST_DONE;
            end
            ST_DONE: begin
               if (!mov) begin
                  moc   <= 1'b0;
                  err   <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage has no reset; the write strobe is masked by reset so an
   // aborted store never lands.
   assign memWe = (state == ST_ACCESS) && !latRw && latLegal && !reset;

   always_ff @(posedge clk) begin
      if (memWe) mem[latIdx] <= latWdata;
   end

endmodule
